// File: rtl/request_priority_encoder.sv
// Sequential priority encoder.
// Request lines are captured into a sticky pending vector. The index of the
// highest-priority pending line is presented over a valid/ready handshake.
// A line is cleared when its code is accepted.
module request_priority_encoder #(
  parameter int N        = 8,
  parameter int CW       = 3,
  parameter int HI_FIRST = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [N-1:0]  req,
  input  logic          code_ready,
  output logic [CW-1:0] code,
  output logic          code_valid,
  output logic [N-1:0]  pending,
  output logic          lost
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t        r_state;
  logic [N-1:0]  r_pending;
  logic [CW-1:0] r_code;
  logic          r_code_valid;
  logic          r_lost;

  logic          w_acc;
  logic [N-1:0]  w_clr;
  logic [N-1:0]  w_set;
  logic [N-1:0]  w_pend_next;
  logic          w_lost_next;
  logic [CW-1:0] w_sel;

  // Index of the winning bit. The scan runs in the order that lets the
  // winner be written last, so no early-exit logic is needed.
  function automatic logic [CW-1:0] f_select(input logic [N-1:0] v);
    logic [CW-1:0] idx;
    idx = '0;
    if (HI_FIRST != 0) begin
      for (int i = 0; i < N; i++) begin
        if (v[i]) idx = CW'(i);
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (v[i]) idx = CW'(i);
      end
    end
    return idx;
  endfunction

  // Next pending vector. A new request on a bit wins over that bit's clear.
  // A collision counts as lost only if the bit is not cleared in the same cycle.
  always_comb begin
    w_acc       = r_code_valid & code_ready;
    w_clr       = w_acc ? (N'(1) << r_code) : '0;
    w_set       = en ? req : '0;
    w_pend_next = (r_pending & ~w_clr) | w_set;
    w_lost_next = |(w_set & r_pending & ~w_clr);
    w_sel       = f_select(w_pend_next);
  end

  // Pending register and the registered lost pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_lost    <= 1'b0;
    end else begin
      r_pending <= w_pend_next;
      r_lost    <= w_lost_next;
    end
  end

  // Handshake FSM. A presented code is held until it is accepted, so
  // higher-priority arrivals never pre-empt it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_code       <= '0;
      r_code_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pend_next != '0) begin
            r_code       <= w_sel;
            r_code_valid <= 1'b1;
            r_state      <= PRESENT;
          end
        end
        PRESENT: begin
          if (w_acc) begin
            if (w_pend_next != '0) begin
              r_code <= w_sel;
            end else begin
              r_code_valid <= 1'b0;
              r_state      <= IDLE;
            end
          end
        end
        default: begin
          r_code_valid <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  assign code       = r_code;
  assign code_valid = r_code_valid;
  assign pending    = r_pending;
  assign lost       = r_lost;

endmodule

// File: tb/tb_request_priority_encoder.sv
// Directed bench for request_priority_encoder (N=8, HI_FIRST=1).
module tb_request_priority_encoder;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic       code_ready;
  logic [2:0] code;
  logic       code_valid;
  logic [7:0] pending;
  logic       lost;

  int errors = 0;
  int checks = 0;

  request_priority_encoder #(.N(8), .CW(3), .HI_FIRST(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .req        (req),
    .code_ready (code_ready),
    .code       (code),
    .code_valid (code_valid),
    .pending    (pending),
    .lost       (lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; req = 8'h00; code_ready = 1'b0;
    #2;
    chk("rst_valid",   32'(code_valid), 32'd0);
    chk("rst_pending", 32'(pending),    32'h00);
    chk("rst_code",    32'(code),       32'd0);
    chk("rst_lost",    32'(lost),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request line, consumer always ready
    en = 1'b1; req = 8'h20; code_ready = 1'b1;
    tick();
    chk("t1_code",    32'(code),       32'd5);
    chk("t1_valid",   32'(code_valid), 32'd1);
    chk("t1_pending", 32'(pending),    32'h20);
    req = 8'h00;
    tick();
    chk("t1_valid_off", 32'(code_valid), 32'd0);
    chk("t1_pend_off",  32'(pending),    32'h00);
    chk("t1_lost",      32'(lost),       32'd0);

    // All lines at once: strict priority drain, one code per cycle
    req = 8'hFF;
    tick();
    chk("t2_code7",  32'(code),       32'd7);
    chk("t2_valid7", 32'(code_valid), 32'd1);
    chk("t2_pendFF", 32'(pending),    32'hFF);
    req = 8'h00;
    for (int i = 6; i >= 0; i--) begin
      tick();
      chk("t2_code",  32'(code),       32'(i));
      chk("t2_valid", 32'(code_valid), 32'd1);
    end
    tick();
    chk("t2_done_valid", 32'(code_valid), 32'd0);
    chk("t2_done_pend",  32'(pending),    32'h00);

    // No preemption while stalled
    code_ready = 1'b0; req = 8'h04;
    tick();
    chk("t3_code2", 32'(code), 32'd2);
    req = 8'h40;
    tick();
    chk("t3_hold_code", 32'(code),       32'd2);
    chk("t3_hold_pend", 32'(pending),    32'h44);
    chk("t3_hold_vld",  32'(code_valid), 32'd1);
    req = 8'h00;
    tick();
    chk("t3_hold2_code", 32'(code), 32'd2);
    code_ready = 1'b1;
    tick();
    chk("t3_code6", 32'(code),    32'd6);
    chk("t3_pend",  32'(pending), 32'h40);
    tick();
    chk("t3_idle", 32'(code_valid), 32'd0);

    // Lost on re-request of a pending bit; no lost when it coincides with accept
    code_ready = 1'b0; req = 8'h08;
    tick();
    chk("t4_code3", 32'(code), 32'd3);
    chk("t4_lost0", 32'(lost), 32'd0);
    tick();
    chk("t4_lost1", 32'(lost), 32'd1);
    req = 8'h00;
    tick();
    chk("t4_lost_pulse", 32'(lost),    32'd0);
    chk("t4_pend",       32'(pending), 32'h08);
    req = 8'h08; code_ready = 1'b1;
    tick();
    chk("t4_acc_lost",  32'(lost),       32'd0);
    chk("t4_repend",    32'(pending),    32'h08);
    chk("t4_re_code",   32'(code),       32'd3);
    chk("t4_re_valid",  32'(code_valid), 32'd1);
    req = 8'h00;
    tick();
    chk("t4_idle",      32'(code_valid), 32'd0);
    chk("t4_code_hold", 32'(code),       32'd3);

    // Capture disabled
    en = 1'b0; req = 8'hFF; code_ready = 1'b0;
    tick();
    tick();
    chk("t5_pend",  32'(pending),    32'h00);
    chk("t5_valid", 32'(code_valid), 32'd0);
    en = 1'b1; req = 8'h01;
    tick();
    chk("t5_resume_code",  32'(code),       32'd0);
    chk("t5_resume_valid", 32'(code_valid), 32'd1);
    en = 1'b0; req = 8'hFF; code_ready = 1'b1;
    tick();
    chk("t5_drain_pend",  32'(pending),    32'h00);
    chk("t5_drain_valid", 32'(code_valid), 32'd0);
    chk("t5_drain_lost",  32'(lost),       32'd0);

    // Asynchronous reset mid-handshake
    en = 1'b1; req = 8'h90; code_ready = 1'b0;
    tick();
    chk("t6_code7", 32'(code), 32'd7);
    req = 8'h80;
    tick();
    chk("t6_lost1", 32'(lost), 32'd1);
    req = 8'h00;
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", 32'(code_valid), 32'd0);
    chk("t6_pend",  32'(pending),    32'h00);
    chk("t6_lost",  32'(lost),       32'd0);
    chk("t6_code",  32'(code),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    code_ready = 1'b1;
    tick();
    chk("t6_post_valid", 32'(code_valid), 32'd0);
    tick();
    chk("t6_post_valid2", 32'(code_valid), 32'd0);
    chk("t6_post_pend",   32'(pending),    32'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
